// File: rtl/idct_row_1d.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | idct_row_1d : streaming 8-point 1-D integer IDCT, one sample per clock     |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module idct_row_1d #(
  parameter int SHIFT = 7,
  parameter int ACC_W = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] in_data,
  input  logic               in_valid,
  input  logic               flush,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  output logic               vec_start
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  // Row k holds the basis weights for coefficient x[k], column n for output y[n].
  localparam logic signed [7:0] c_coef [64] = '{
     8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,
     8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89,
     8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83,
     8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75,
     8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64,
     8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50,
     8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36,
     8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18
  };

  localparam logic signed [ACC_W-1:0] c_round   = ACC_W'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(-32768);

  logic [2:0]         r_in_cnt;
  logic               r_calc_pend;
  logic [0:0]         r_state;
  logic [2:0]         r_out_cnt;
  logic signed [15:0] r_x_reg    [7];
  logic signed [15:0] r_work_reg [8];
  logic signed [15:0] r_out_reg  [8];
  logic signed [15:0] w_y        [8];
  logic               w_capture;
  logic               w_last;

  assign w_capture = in_valid & ~flush;
  assign w_last    = w_capture & (r_in_cnt == 3'd7);

  always_comb begin : p_compute
    logic signed [ACC_W-1:0] v_acc;
    v_acc = '0;
    w_y   = '{default: '0};
    for (int n = 0; n < 8; n++) begin
      v_acc = '0;
      for (int k = 0; k < 8; k++) begin
        v_acc = v_acc + ACC_W'(r_work_reg[k]) * ACC_W'(c_coef[k*8 + n]);
      end
      v_acc = (v_acc + c_round) >>> SHIFT;
      if (v_acc > c_sat_max) begin
        v_acc = c_sat_max;
      end else if (v_acc < c_sat_min) begin
        v_acc = c_sat_min;
      end
      w_y[n] = v_acc[15:0];
    end
  end

  // Data storage carries no reset; its contents are only read once re-qualified.
  always_ff @(posedge clk) begin
    if (w_capture && (r_in_cnt != 3'd7)) begin
      r_x_reg[r_in_cnt] <= in_data;
    end
    if (w_last) begin
      for (int k = 0; k < 7; k++) begin
        r_work_reg[k] <= r_x_reg[k];
      end
      r_work_reg[7] <= in_data;
    end
    if (r_calc_pend && !flush) begin
      r_out_reg <= w_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt    <= 3'd0;
      r_calc_pend <= 1'b0;
      r_state     <= S_IDLE;
      r_out_cnt   <= 3'd0;
      out_data    <= 16'sd0;
      out_valid   <= 1'b0;
      vec_start   <= 1'b0;
    end else if (flush) begin
      r_in_cnt    <= 3'd0;
      r_calc_pend <= 1'b0;
      r_state     <= S_IDLE;
      r_out_cnt   <= 3'd0;
      out_data    <= 16'sd0;
      out_valid   <= 1'b0;
      vec_start   <= 1'b0;
    end else begin
      r_calc_pend <= w_last;
      if (in_valid) begin
        r_in_cnt <= r_in_cnt + 3'd1;
      end

      if (r_state == S_EMIT) begin
        out_data  <= r_out_reg[r_out_cnt];
        out_valid <= 1'b1;
        vec_start <= (r_out_cnt == 3'd0);
      end else begin
        out_data  <= 16'sd0;
        out_valid <= 1'b0;
        vec_start <= 1'b0;
      end

      // A fresh compute wins over the end-of-burst return, keeping back-to-back output.
      if (r_calc_pend) begin
        r_state   <= S_EMIT;
        r_out_cnt <= 3'd0;
      end else if (r_state == S_EMIT) begin
        if (r_out_cnt == 3'd7) begin
          r_state   <= S_IDLE;
          r_out_cnt <= 3'd0;
        end else begin
          r_out_cnt <= r_out_cnt + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idct_row_1d.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_idct_row_1d : self-checking bench for idct_row_1d against a matrix model|
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_idct_row_1d;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               flush;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               vec_start;

  always #5 clk = ~clk;

  idct_row_1d #(.SHIFT(7), .ACC_W(28)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .vec_start (vec_start)
  );

  int C [8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}
  };

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  longint last_cyc;
  int     q_out [$];
  bit     q_vs  [$];
  longint q_cyc [$];
  int     eq    [$];
  bit     ev    [$];
  int     xa [8];
  int     xb [8];
  longint t0, t1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q_out.push_back(int'(out_data));
      q_vs.push_back(vec_start);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_y(input int x[8], input int n);
    longint acc = 0;
    for (int k = 0; k < 8; k++) acc += longint'(C[k][n]) * x[k];
    acc = (acc + 64) >>> 7;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic push_exp(input int x[8], input int cnt);
    for (int n = 0; n < cnt; n++) begin
      eq.push_back(ref_y(x, n));
      ev.push_back(n == 0);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic f);
    @(negedge clk);
    in_data  = 16'(d);
    in_valid = v;
    flush    = f;
    @(posedge clk);
    #1;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
  endtask

  task automatic send_vec(input int x[8], input int gap, output longint t7);
    t7 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(x[k], 1'b1, 1'b0);
      if (k == 7) t7 = last_cyc;
      else if (gap != 0) drive(0, 1'b0, 1'b0);
    end
  endtask

  task automatic rand_vec(output int x[8]);
    logic signed [15:0] r;
    for (int k = 0; k < 8; k++) begin
      r = 16'($urandom);
      x[k] = int'(r);
    end
  endtask

  // y[i] of a burst is expected at capture edge of the first x[7] plus 2 + i.
  task automatic compare(input string tag, input longint tref);
    int m;
    chk({tag, "_count"}, q_out.size(), eq.size());
    m = (q_out.size() < eq.size()) ? q_out.size() : eq.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_y%0d", tag, i), q_out[i], eq[i]);
      chk($sformatf("%s_vs%0d", tag, i), q_vs[i], ev[i]);
      chk($sformatf("%s_cyc%0d", tag, i), q_cyc[i], tref + 2 + i);
    end
    q_out.delete(); q_vs.delete(); q_cyc.delete(); eq.delete(); ev.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_vec_start", vec_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    xa = '{64, 0, 0, 0, 0, 0, 0, 0};
    send_vec(xa, 0, t0); idle(12); push_exp(xa, 8); compare("dc", t0);

    xa = '{0, 128, 0, 0, 0, 0, 0, 0};
    send_vec(xa, 0, t0); idle(12); push_exp(xa, 8); compare("impulse", t0);

    xa = '{default: 32767};
    send_vec(xa, 0, t0); idle(12); push_exp(xa, 8); compare("sat_pos", t0);

    xa = '{default: -32768};
    send_vec(xa, 0, t0); idle(12); push_exp(xa, 8); compare("sat_neg", t0);

    for (int v = 0; v < 4; v++) begin
      rand_vec(xa);
      send_vec(xa, 0, t1);
      if (v == 0) t0 = t1;
      push_exp(xa, 8);
    end
    idle(12);
    compare("stream", t0);

    rand_vec(xa);
    send_vec(xa, 1, t0); idle(12); push_exp(xa, 8); compare("gapped", t0);
    chk("gapped_idle", out_valid, 0);

    // Flush mid-load and mid-emit: burst is cut, next eight samples are a clean vector.
    rand_vec(xa);
    send_vec(xa, 0, t0);
    for (int i = 0; i < 5; i++) drive(int'(16'($urandom)), 1'b1, 1'b0);
    drive(int'(16'($urandom)), 1'b1, 1'b1);
    chk("flush_cut_valid", out_valid, 0);
    idle(12); push_exp(xa, 4); compare("flush_cut", t0);
    rand_vec(xb);
    send_vec(xb, 0, t0); idle(12); push_exp(xb, 8); compare("flush_next", t0);

    // Same disruption through an asynchronous reset pulse.
    rand_vec(xa);
    send_vec(xa, 0, t0);
    for (int i = 0; i < 5; i++) drive(int'(16'($urandom)), 1'b1, 1'b0);
    chk("rst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_data", out_data, 0);
    chk("rst_async_vs", vec_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp(xa, 3); compare("rst_cut", t0);
    rand_vec(xb);
    send_vec(xb, 0, t0); idle(12); push_exp(xb, 8); compare("rst_next", t0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
